// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
// Round-robin access controller that lets two requesters share one single-port
// OpenRAM SRAM macro. Each requester presents a read or write request over a
// valid/ready handshake. The controller sequences the macro's active-low pins
// and owns the tri-state data bus. Read data is returned to the requester that
// issued the read.
//
// Ports:
//   clk, rst                   clock shared with the macro; synchronous active-high reset
//   req_valid_0/1, req_ready_0/1  request handshake per requester
//   req_we_0/1                 1 = write, 0 = read
//   req_addr_0/1, req_wdata_0/1   word address and write data
//   rsp_valid_0/1              one-cycle pulse when read data is returned
//   rsp_rdata_0/1              read data, held until the next read for that requester
//   sram_csb/web/oeb           active-low chip select, write enable and output enable
//   sram_addr                  macro address, holds its value while idle
//   sram_data                  bidirectional macro data bus
//   busy                       high whenever a transaction is in flight

module sram_rr_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, RCAP} state_t;

  state_t                          state_q, state_d;
  logic                            ptr_q, ptr_d;
  logic                            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [1:0]                      rsp_valid_q, rsp_valid_d;
  logic                            csb_q, csb_d;
  logic                            web_q, web_d;
  logic                            oeb_q, oeb_d;
  logic                            drive_q, drive_d;
  logic                            busy_q, busy_d;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       accept;

  assign valid = {req_valid_1, req_valid_0};

  // A lone requester always wins; on a tie the pointer names the winner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = valid[gi] && (!valid[1-gi] || (ptr_q == 1'(gi)));
  end

  assign accept      = (state_q == IDLE) && (grant != 2'b00);
  assign req_ready_0 = (state_q == IDLE) && grant[0];
  assign req_ready_1 = (state_q == IDLE) && grant[1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 2'b00;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          ptr_d   = !grant[1];
          addr_d  = grant[1] ? req_addr_1  : req_addr_0;
          wdata_d = grant[1] ? req_wdata_1 : req_wdata_0;
          state_d = (grant[1] ? req_we_1 : req_we_0) ? WR : RD;
        end
      end
      WR:   state_d = IDLE;
      RD:   state_d = RCAP;
      RCAP: begin
        // The macro has been driving DATA since RD; sample it at the end of RCAP.
        rdata_d[owner_q]     = sram_data;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from the next state so they change cleanly on the edge.
    csb_d   = (state_d == IDLE);
    web_d   = (state_d != WR);
    oeb_d   = !((state_d == RD) || (state_d == RCAP));
    drive_d = (state_d == WR);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
    end
  end

  // The bus is driven only during WR; the macro drives it only while reading.
  assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign sram_csb    = csb_q;
  assign sram_web    = web_q;
  assign sram_oeb    = oeb_q;
  assign sram_addr   = addr_q;
  assign busy        = busy_q;
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_rdata_0 = rdata_q[0];
  assign rsp_rdata_1 = rdata_q[1];

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: a simple SRAM macro model on the shared bus, a
// transaction-timeline reference model compared on every cycle, and directed
// scenarios with hand-computed literal expectations.

module tb_sram_rr_arbiter;

  localparam int DW = 2;
  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          req_valid_0, req_ready_0, req_we_0;
  logic [AW-1:0] req_addr_0;
  logic [DW-1:0] req_wdata_0;
  logic          rsp_valid_0;
  logic [DW-1:0] rsp_rdata_0;
  logic          req_valid_1, req_ready_1, req_we_1;
  logic [AW-1:0] req_addr_1;
  logic [DW-1:0] req_wdata_1;
  logic          rsp_valid_1;
  logic [DW-1:0] rsp_rdata_1;
  logic          sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          busy;

  int errors = 0;
  int checks = 0;

  sram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_addr(sram_addr), .sram_data(sram_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM macro model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int a = 0; a < (1<<AW); a++) mem[a] = 2'(a);
  always @(posedge clk) if (!sram_csb && !sram_web) mem[sram_addr] <= sram_data;
  assign sram_data = (!sram_csb && !sram_oeb && sram_web) ? mem[sram_addr] : {DW{1'bz}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted transaction appends the cycles it will occupy to a timeline;
  // an empty timeline means the controller is idle.
  typedef struct packed {
    logic idle;
    logic wr;
    logic rcap;
    logic rsp0;
    logic rsp1;
  } cyc_t;
  localparam cyc_t IDLE_C = '{idle: 1'b1, wr: 1'b0, rcap: 1'b0, rsp0: 1'b0, rsp1: 1'b0};
  localparam cyc_t WR_C   = '{idle: 1'b0, wr: 1'b1, rcap: 1'b0, rsp0: 1'b0, rsp1: 1'b0};
  localparam cyc_t RD_C   = '{idle: 1'b0, wr: 1'b0, rcap: 1'b0, rsp0: 1'b0, rsp1: 1'b0};
  localparam cyc_t RCAP_C = '{idle: 1'b0, wr: 1'b0, rcap: 1'b1, rsp0: 1'b0, rsp1: 1'b0};

  cyc_t          tl[$];
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  logic          m_on = 1'b0;
  logic          m_ptr = 1'b0;
  logic          m_owner = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd0 = '0;
  logic [DW-1:0] m_rd1 = '0;
  initial for (int a = 0; a < (1<<AW); a++) mem_m[a] = 2'(a);

  always @(negedge clk) begin
    cyc_t cur;
    cyc_t rsp_c;
    logic g0, g1;
    cur = (tl.size() > 0) ? tl[0] : IDLE_C;
    g0  = req_valid_0 && (!req_valid_1 || (m_ptr == 1'b0));
    g1  = req_valid_1 && (!req_valid_0 || (m_ptr == 1'b1));
    if (m_on) begin
      chk("csb", 32'(sram_csb), 32'(cur.idle));
      chk("web", 32'(sram_web), 32'(!cur.wr));
      chk("oeb", 32'(sram_oeb), 32'(cur.idle || cur.wr));
      chk("busy", 32'(busy), 32'(!cur.idle));
      chk("ready_0", 32'(req_ready_0), 32'(cur.idle && g0));
      chk("ready_1", 32'(req_ready_1), 32'(cur.idle && g1));
      chk("sram_addr", 32'(sram_addr), 32'(m_addr));
      chk("rsp_valid_0", 32'(rsp_valid_0), 32'(cur.rsp0));
      chk("rsp_valid_1", 32'(rsp_valid_1), 32'(cur.rsp1));
      chk("rsp_rdata_0", 32'(rsp_rdata_0), 32'(m_rd0));
      chk("rsp_rdata_1", 32'(rsp_rdata_1), 32'(m_rd1));
      if (cur.wr) chk("wr_bus_data", 32'(sram_data), 32'(m_wdata));
    end
    // Advance to the state after the coming rising edge.
    if (rst) begin
      if (m_on && cur.wr) mem_m[m_addr] = m_wdata;
      tl.delete();
      m_on = 1'b1; m_ptr = 1'b0; m_owner = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      if (cur.wr) mem_m[m_addr] = m_wdata;
      if (cur.rcap) begin
        if (m_owner) m_rd1 = mem_m[m_addr];
        else         m_rd0 = mem_m[m_addr];
      end
      if (tl.size() > 0) void'(tl.pop_front());
      if (cur.idle && (g0 || g1)) begin
        m_owner = g1;
        m_ptr   = !g1;
        m_addr  = g1 ? req_addr_1 : req_addr_0;
        m_wdata = g1 ? req_wdata_1 : req_wdata_0;
        if (g1 ? req_we_1 : req_we_0) begin
          tl.push_back(WR_C);
        end else begin
          rsp_c      = IDLE_C;
          rsp_c.rsp0 = !g1;
          rsp_c.rsp1 = g1;
          tl.push_back(RD_C);
          tl.push_back(RCAP_C);
          tl.push_back(rsp_c);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(posedge clk); #1;
    if (who == 0) begin
      req_we_0 = we; req_addr_0 = a; req_wdata_0 = d; req_valid_0 = 1'b1;
    end else begin
      req_we_1 = we; req_addr_1 = a; req_wdata_1 = d; req_valid_1 = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((who == 0) ? req_ready_0 : req_ready_1) && n < 20);
    chk("grant_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    if (who == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
  endtask

  task automatic read_req(input int who, input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n;
    issue(who, 1'b0, a, '0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((who == 0) ? rsp_valid_0 : rsp_valid_1) && n < 20);
    chk("rd_latency", 32'(n), 32'd3);
    d = (who == 0) ? rsp_rdata_0 : rsp_rdata_1;
    $display("txn: req%0d read  addr %02h -> %0d (rsp after %0d cycles)", who, a, d, n);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DW-1:0] d;
    int who;
    int n;
    int web_lows;

    rst = 1'b1;
    req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 7'h10; req_wdata_0 = 2'b01;
    req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 7'h11; req_wdata_1 = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with both requests pending.
    @(negedge clk);
    chk("rst_csb", 32'(sram_csb), 32'd1);
    chk("rst_web", 32'(sram_web), 32'd1);
    chk("rst_oeb", 32'(sram_oeb), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rsp_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    chk("rst_ready", 32'({req_ready_1, req_ready_0}), 32'b01);

    // Contention: grants must alternate starting with requester 0.
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req_ready_0 || req_ready_1) && n < 20) begin @(negedge clk); n++; end
      who = req_ready_1 ? 1 : 0;
      chk("contention_grant", 32'(who), 32'(g % 2));
      $display("txn: req%0d write (contention round %0d)", who, g);
      @(posedge clk); #1;
      if (g == 3) begin req_valid_0 = 1'b0; req_valid_1 = 1'b0; end
      @(negedge clk);
    end
    read_req(0, 7'h10, d);
    chk("contention_rb0", 32'(d), 32'b01);
    read_req(1, 7'h11, d);
    chk("contention_rb1", 32'(d), 32'b11);

    // Write then read, requester 0.
    issue(0, 1'b1, 7'h05, 2'b10);
    $display("txn: req0 write addr 05 <- 2");
    web_lows = 0;
    repeat (3) begin
      @(negedge clk);
      if (!sram_web) begin
        web_lows++;
        chk("wr_pin_data", 32'(sram_data), 32'b10);
      end
    end
    chk("web_low_cycles", 32'(web_lows), 32'd1);
    read_req(0, 7'h05, d);
    chk("wr_rd_data", 32'(d), 32'b10);

    // Single requester streaming reads of the preloaded words.
    for (int i = 0; i < 4; i++) begin
      read_req(1, 7'(i), d);
      chk("stream_data", 32'(d), 32'(i));
    end

    // Reset during RCAP: no response, controller idle afterwards.
    issue(0, 1'b0, 7'h02, '0);
    $display("txn: req0 read  addr 02 interrupted by reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    chk("midrst_csb", 32'(sram_csb), 32'd1);
    read_req(0, 7'h03, d);
    chk("post_rst_read", 32'(d), 32'd3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
